// File: rtl/rd_tag_scheduler.sv
// Read-request scheduler and tag pool: arbitrates two requesters onto one RQ issue slot,
// keeps per-tag context and retires or replays each tag on completion.
module rd_tag_scheduler #(
   parameter int unsigned TAG_W     = 4,
   parameter int unsigned ADDR_W    = 64,
   parameter int unsigned MAX_RETRY = 3
) (
   input  logic              clk,
   input  logic              rstn,
   input  logic              srst,
   input  logic              req0_valid,
   output logic              req0_ready,
   input  logic [ADDR_W-1:0] req0_addr,
   input  logic [4:0]        req0_len,
   input  logic              req1_valid,
   output logic              req1_ready,
   input  logic [ADDR_W-1:0] req1_addr,
   input  logic [4:0]        req1_len,
   output logic              rq_valid,
   input  logic              rq_ready,
   output logic [ADDR_W-1:0] rq_addr,
   output logic [4:0]        rq_len,
   output logic [7:0]        rq_tag,
   input  logic [7:0]        select_tag,
   input  logic              select_tag_valid,
   input  logic              select_replay_cfg,
   output logic              done_valid,
   output logic              done_req,
   output logic [7:0]        done_tag,
   output logic              done_err,
   output logic              unexp_cpl,
   output logic [TAG_W:0]    outstanding
);
   localparam int unsigned NUM_TAGS = 1 << TAG_W;

   logic [NUM_TAGS-1:0]       r_busy;
   logic [NUM_TAGS-1:0]       r_rpend;
   logic [NUM_TAGS-1:0]       r_owner;
   logic [NUM_TAGS-1:0][2:0]  r_retry;
   logic [ADDR_W-1:0]         r_ctx_addr [NUM_TAGS];
   logic [4:0]                r_ctx_len  [NUM_TAGS];
   logic                      r_rr;  // 1: req1 wins the next tie
   logic                      r_rq_valid;
   logic [ADDR_W-1:0]         r_rq_addr;
   logic [4:0]                r_rq_len;
   logic [TAG_W-1:0]          r_rq_tag;
   logic                      r_done_valid;
   logic                      r_done_req;
   logic                      r_done_err;
   logic [TAG_W-1:0]          r_done_tag;
   logic                      r_unexp;

   logic                      w_run;
   logic                      w_load;
   logic                      w_new;
   logic                      w_gnt0;
   logic                      w_gnt1;
   logic                      w_rp_any;
   logic [TAG_W-1:0]          w_rp_idx;
   logic                      w_free_any;
   logic [TAG_W-1:0]          w_free_idx;
   logic [TAG_W:0]            w_cnt;
   logic [TAG_W-1:0]          w_cpl_idx;
   logic                      w_cpl_in;
   logic                      w_cpl_hit;
   logic                      w_retry_ok;

   // Downward scan so the last hit is the lowest index.
   always_comb begin
      w_rp_any   = 1'b0;
      w_rp_idx   = '0;
      w_free_any = 1'b0;
      w_free_idx = '0;
      w_cnt      = '0;
      for (int i = NUM_TAGS - 1; i >= 0; i--) begin
         if (r_rpend[i]) begin
            w_rp_any = 1'b1;
            w_rp_idx = TAG_W'(i);
         end
         if (!r_busy[i]) begin
            w_free_any = 1'b1;
            w_free_idx = TAG_W'(i);
         end
         w_cnt = w_cnt + (TAG_W+1)'(r_busy[i]);
      end
   end

   assign w_run      = rstn & ~srst;
   assign w_load     = ~r_rq_valid | rq_ready;
   assign w_new      = w_run & w_load & ~w_rp_any & w_free_any;
   assign w_gnt0     = w_new & req0_valid & (~req1_valid | ~r_rr);
   assign w_gnt1     = w_new & req1_valid & (~req0_valid | r_rr);
   assign w_cpl_idx  = select_tag[TAG_W-1:0];
   assign w_cpl_in   = select_tag < 8'(NUM_TAGS);
   assign w_cpl_hit  = w_cpl_in & r_busy[w_cpl_idx] & ~r_rpend[w_cpl_idx];
   assign w_retry_ok = r_retry[w_cpl_idx] < 3'(MAX_RETRY);

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         r_busy       <= '0;
         r_rpend      <= '0;
         r_owner      <= '0;
         r_retry      <= '0;
         r_rr         <= 1'b0;
         r_rq_valid   <= 1'b0;
         r_rq_addr    <= '0;
         r_rq_len     <= '0;
         r_rq_tag     <= '0;
         r_done_valid <= 1'b0;
         r_done_req   <= 1'b0;
         r_done_err   <= 1'b0;
         r_done_tag   <= '0;
         r_unexp      <= 1'b0;
      end else if (srst) begin
         r_busy       <= '0;
         r_rpend      <= '0;
         r_owner      <= '0;
         r_retry      <= '0;
         r_rr         <= 1'b0;
         r_rq_valid   <= 1'b0;
         r_rq_addr    <= '0;
         r_rq_len     <= '0;
         r_rq_tag     <= '0;
         r_done_valid <= 1'b0;
         r_done_req   <= 1'b0;
         r_done_err   <= 1'b0;
         r_done_tag   <= '0;
         r_unexp      <= 1'b0;
      end else begin
         r_done_valid <= 1'b0;
         r_unexp      <= 1'b0;
         if (w_load) begin
            if (w_rp_any) begin
               r_rq_valid        <= 1'b1;
               r_rq_addr         <= r_ctx_addr[w_rp_idx];
               r_rq_len          <= r_ctx_len[w_rp_idx];
               r_rq_tag          <= w_rp_idx;
               r_rpend[w_rp_idx] <= 1'b0;
            end else if (w_gnt0 | w_gnt1) begin
               r_rq_valid          <= 1'b1;
               r_rq_addr           <= w_gnt1 ? req1_addr : req0_addr;
               r_rq_len            <= w_gnt1 ? req1_len : req0_len;
               r_rq_tag            <= w_free_idx;
               r_busy[w_free_idx]  <= 1'b1;
               r_owner[w_free_idx] <= w_gnt1;
               r_retry[w_free_idx] <= '0;
               r_rr                <= w_gnt0;
            end else begin
               r_rq_valid <= 1'b0;
            end
         end
         // Completion only touches a busy tag, which allocation can never pick.
         if (select_tag_valid) begin
            if (!w_cpl_hit) begin
               r_unexp <= 1'b1;
            end else if (select_replay_cfg && w_retry_ok) begin
               r_retry[w_cpl_idx] <= r_retry[w_cpl_idx] + 3'd1;
               r_rpend[w_cpl_idx] <= 1'b1;
            end else begin
               r_busy[w_cpl_idx] <= 1'b0;
               r_done_valid      <= 1'b1;
               r_done_req        <= r_owner[w_cpl_idx];
               r_done_tag        <= w_cpl_idx;
               r_done_err        <= select_replay_cfg;
            end
         end
      end
   end

   always_ff @(posedge clk) begin
      if (w_gnt0 | w_gnt1) begin
         r_ctx_addr[w_free_idx] <= w_gnt1 ? req1_addr : req0_addr;
         r_ctx_len[w_free_idx]  <= w_gnt1 ? req1_len : req0_len;
      end
   end

   assign req0_ready  = w_gnt0;
   assign req1_ready  = w_gnt1;
   assign rq_valid    = r_rq_valid;
   assign rq_addr     = r_rq_addr;
   assign rq_len      = r_rq_len;
   assign rq_tag      = {{(8-TAG_W){1'b0}}, r_rq_tag};
   assign done_valid  = r_done_valid;
   assign done_req    = r_done_req;
   assign done_tag    = {{(8-TAG_W){1'b0}}, r_done_tag};
   assign done_err    = r_done_err;
   assign unexp_cpl   = r_unexp;
   assign outstanding = w_cnt;

endmodule

// File: tb/tb_rd_tag_scheduler.sv
// Scoreboard bench for rd_tag_scheduler: expected RQ issues and done pulses are queued
// when stimulus is driven and compared when the DUT produces them.
module tb_rd_tag_scheduler;
   localparam int unsigned TAG_W     = 4;
   localparam int unsigned ADDR_W    = 64;
   localparam int unsigned MAX_RETRY = 3;

   typedef struct packed {
      logic [63:0] addr;
      logic [4:0]  len;
      logic [7:0]  tag;
   } rq_t;

   typedef struct packed {
      logic       req;
      logic [7:0] tag;
      logic       err;
   } dn_t;

   logic              clk = 1'b0;
   logic              rstn, srst;
   logic              req0_valid, req0_ready, req1_valid, req1_ready;
   logic [ADDR_W-1:0] req0_addr, req1_addr, rq_addr;
   logic [4:0]        req0_len, req1_len, rq_len;
   logic              rq_valid, rq_ready;
   logic [7:0]        rq_tag, select_tag, done_tag;
   logic              select_tag_valid, select_replay_cfg;
   logic              done_valid, done_req, done_err, unexp_cpl;
   logic [TAG_W:0]    outstanding;

   int  n_checks = 0;
   int  n_errors = 0;
   int  n_unexp_exp = 0;
   rq_t exp_rq[$];
   dn_t exp_done[$];
   rq_t mon_rq;
   dn_t mon_dn;

   logic [63:0] m_addr [32];
   logic [4:0]  m_len  [32];
   logic        m_own  [32];

   rd_tag_scheduler #(
      .TAG_W     (TAG_W),
      .ADDR_W    (ADDR_W),
      .MAX_RETRY (MAX_RETRY)
   ) u_dut (
      .clk               (clk),
      .rstn              (rstn),
      .srst              (srst),
      .req0_valid        (req0_valid),
      .req0_ready        (req0_ready),
      .req0_addr         (req0_addr),
      .req0_len          (req0_len),
      .req1_valid        (req1_valid),
      .req1_ready        (req1_ready),
      .req1_addr         (req1_addr),
      .req1_len          (req1_len),
      .rq_valid          (rq_valid),
      .rq_ready          (rq_ready),
      .rq_addr           (rq_addr),
      .rq_len            (rq_len),
      .rq_tag            (rq_tag),
      .select_tag        (select_tag),
      .select_tag_valid  (select_tag_valid),
      .select_replay_cfg (select_replay_cfg),
      .done_valid        (done_valid),
      .done_req          (done_req),
      .done_tag          (done_tag),
      .done_err          (done_err),
      .unexp_cpl         (unexp_cpl),
      .outstanding       (outstanding)
   );

   always #5 clk = ~clk;

   task automatic check_eq(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic push_rq(input logic [63:0] addr, input logic [4:0] len, input int tag);
      rq_t e;
      e.addr = addr;
      e.len  = len;
      e.tag  = 8'(tag);
      exp_rq.push_back(e);
   endtask

   task automatic issue(input int who, input logic [63:0] addr, input logic [4:0] len,
                        input int tag);
      bit got;
      got = 1'b0;
      @(posedge clk); #1;
      if (who == 0) begin
         req0_valid = 1'b1; req0_addr = addr; req0_len = len;
      end else begin
         req1_valid = 1'b1; req1_addr = addr; req1_len = len;
      end
      for (int c = 0; c < 50 && !got; c++) begin
         @(negedge clk);
         if ((who == 0) ? req0_ready : req1_ready) got = 1'b1;
      end
      check_eq("grant", 64'(got), 64'd1);
      if (got) begin
         push_rq(addr, len, tag);
         m_addr[tag] = addr;
         m_len[tag]  = len;
         m_own[tag]  = (who != 0);
      end
      @(posedge clk); #1;
      req0_valid = 1'b0;
      req1_valid = 1'b0;
      @(negedge clk);
      check_eq("grant_lat", 64'(rq_valid), 64'd1);
   endtask

   // kind: 0 clean retire, 1 replay, 2 retire with error, 3 unexpected
   task automatic cpl(input int tag, input bit err, input int kind);
      dn_t d;
      logic [1:0] exp_p;
      @(posedge clk); #1;
      select_tag        = 8'(tag);
      select_tag_valid  = 1'b1;
      select_replay_cfg = err;
      if (kind == 0 || kind == 2) begin
         d.req = m_own[tag];
         d.tag = 8'(tag);
         d.err = (kind == 2);
         exp_done.push_back(d);
      end else if (kind == 1) begin
         push_rq(m_addr[tag], m_len[tag], tag);
      end else begin
         n_unexp_exp++;
      end
      @(posedge clk); #1;
      select_tag_valid  = 1'b0;
      select_replay_cfg = 1'b0;
      @(negedge clk);
      exp_p = (kind == 0 || kind == 2) ? 2'b10 : ((kind == 3) ? 2'b01 : 2'b00);
      check_eq("cpl_pulse", 64'({done_valid, unexp_cpl}), 64'(exp_p));
   endtask

   task automatic wait_drain();
      int c;
      c = 0;
      while ((exp_rq.size() != 0 || exp_done.size() != 0) && c < 100) begin
         @(negedge clk);
         c++;
      end
      check_eq("drain", 64'(exp_rq.size() + exp_done.size()), 64'd0);
   endtask

   always @(negedge clk) begin
      if (rstn) begin
         if (rq_valid && rq_ready) begin
            if (exp_rq.size() == 0) begin
               check_eq("rq_extra", 64'd1, 64'd0);
            end else begin
               mon_rq = exp_rq.pop_front();
               check_eq("rq_addr", rq_addr, mon_rq.addr);
               check_eq("rq_len", 64'(rq_len), 64'(mon_rq.len));
               check_eq("rq_tag", 64'(rq_tag), 64'(mon_rq.tag));
            end
         end
         if (done_valid) begin
            if (exp_done.size() == 0) begin
               check_eq("done_extra", 64'd1, 64'd0);
            end else begin
               mon_dn = exp_done.pop_front();
               check_eq("done_req", 64'(done_req), 64'(mon_dn.req));
               check_eq("done_tag", 64'(done_tag), 64'(mon_dn.tag));
               check_eq("done_err", 64'(done_err), 64'(mon_dn.err));
            end
         end
         if (unexp_cpl) begin
            if (n_unexp_exp == 0) check_eq("unexp_extra", 64'd1, 64'd0);
            else n_unexp_exp--;
         end
      end
   end

   initial begin
      #300000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int  k, c, who;
      bit  granted, changed;
      logic [63:0] a0;
      logic [7:0]  t0;

      rstn = 1'b0; srst = 1'b0; rq_ready = 1'b1;
      req0_valid = 1'b1; req0_addr = '0; req0_len = '0;
      req1_valid = 1'b0; req1_addr = '0; req1_len = '0;
      select_tag = '0; select_tag_valid = 1'b0; select_replay_cfg = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_rq_valid", 64'(rq_valid), 64'd0);
      check_eq("rst_rq_addr", rq_addr, 64'd0);
      check_eq("rst_rq_tag", 64'(rq_tag), 64'd0);
      check_eq("rst_out", 64'(outstanding), 64'd0);
      check_eq("rst_ready", 64'(req0_ready), 64'd0);
      check_eq("rst_pulses", 64'({done_valid, done_err, unexp_cpl}), 64'd0);
      req0_valid = 1'b0;
      @(posedge clk); #1;
      rstn = 1'b1;

      // single request and clean completion
      issue(0, 64'h1000, 5'd4, 0);
      wait_drain();
      check_eq("single_out", 64'(outstanding), 64'd1);
      cpl(0, 1'b0, 0);
      wait_drain();
      check_eq("single_free", 64'(outstanding), 64'd0);

      // synchronous reset drops context and the round-robin pointer
      issue(0, 64'h1800, 5'd2, 0);
      wait_drain();
      @(posedge clk); #1; srst = 1'b1;
      @(posedge clk); #1; srst = 1'b0;
      check_eq("srst_out", 64'(outstanding), 64'd0);
      check_eq("srst_valid", 64'(rq_valid), 64'd0);

      // round-robin with both requesters held valid
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_addr = 64'h2000; req0_len = 5'd1;
      req1_valid = 1'b1; req1_addr = 64'h2800; req1_len = 5'd2;
      k = 0; c = 0;
      while (k < 4 && c < 40) begin
         @(negedge clk);
         c++;
         if (req0_ready || req1_ready) begin
            who = req1_ready ? 1 : 0;
            check_eq("arb_order", 64'(who), 64'(k % 2));
            check_eq("arb_onehot", 64'(req0_ready & req1_ready), 64'd0);
            push_rq(who ? req1_addr : req0_addr, who ? req1_len : req0_len, k);
            m_addr[k] = who ? req1_addr : req0_addr;
            m_len[k]  = who ? req1_len : req0_len;
            m_own[k]  = (who != 0);
            k++;
            @(posedge clk); #1;
            if (who != 0) begin
               req1_addr = req1_addr + 64'h40; req1_len = req1_len + 5'd1;
            end else begin
               req0_addr = req0_addr + 64'h40; req0_len = req0_len + 5'd1;
            end
         end
      end
      req0_valid = 1'b0; req1_valid = 1'b0;
      check_eq("arb_count", 64'(k), 64'd4);
      wait_drain();
      check_eq("arb_out", 64'(outstanding), 64'd4);
      for (int t = 0; t < 4; t++) cpl(t, 1'b0, 0);
      wait_drain();

      // tag pool exhaustion and reuse of a freed tag
      for (int t = 0; t < 16; t++) issue(0, 64'h8000 + 64'(t) * 64'h100, 5'(t % 16 + 1), t);
      wait_drain();
      check_eq("full_out", 64'(outstanding), 64'd16);
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_addr = 64'h9000; req0_len = 5'd16;
      granted = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (req0_ready) granted = 1'b1;
      end
      check_eq("full_noready", 64'(granted), 64'd0);
      cpl(5, 1'b0, 0);
      check_eq("full_regrant", 64'(req0_ready), 64'd1);
      push_rq(64'h9000, 5'd16, 5);
      m_addr[5] = 64'h9000; m_len[5] = 5'd16; m_own[5] = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_drain();
      for (int t = 0; t < 16; t++) cpl(t, 1'b0, 0);
      wait_drain();
      check_eq("full_free", 64'(outstanding), 64'd0);

      // replays keep the tag and payload, then fail after MAX_RETRY
      issue(0, 64'h3000, 5'd1, 0);
      issue(1, 64'h3100, 5'd2, 1);
      issue(0, 64'h4000, 5'd7, 2);
      wait_drain();
      for (int r = 0; r < 3; r++) begin
         cpl(2, 1'b1, 1);
         wait_drain();
         check_eq("replay_out", 64'(outstanding), 64'd3);
      end
      cpl(2, 1'b1, 2);
      wait_drain();
      check_eq("replay_fail_out", 64'(outstanding), 64'd2);

      // backpressure holds the slot; a pending replay beats a new request
      @(posedge clk); #1;
      rq_ready = 1'b0;
      issue(1, 64'h5000, 5'd3, 2);
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_addr = 64'h6000; req0_len = 5'd9;
      a0 = rq_addr; t0 = rq_tag;
      granted = 1'b0; changed = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (req0_ready || req1_ready) granted = 1'b1;
         if (!rq_valid || rq_addr != a0 || rq_tag != t0) changed = 1'b1;
      end
      check_eq("bp_nogrant", 64'(granted), 64'd0);
      check_eq("bp_stable", 64'(changed), 64'd0);
      check_eq("bp_tag", 64'(t0), 64'd2);
      cpl(0, 1'b1, 1);
      @(posedge clk); #1;
      rq_ready = 1'b1;
      @(negedge clk);
      check_eq("prio_replay", 64'(req0_ready), 64'd0);
      @(negedge clk);
      check_eq("prio_req0", 64'(req0_ready), 64'd1);
      push_rq(64'h6000, 5'd9, 3);
      m_addr[3] = 64'h6000; m_len[3] = 5'd9; m_own[3] = 1'b0;
      @(posedge clk); #1;
      req0_valid = 1'b0;
      wait_drain();
      for (int t = 0; t < 4; t++) cpl(t, 1'b0, 0);
      wait_drain();
      check_eq("bp_free", 64'(outstanding), 64'd0);

      // unexpected completions leave state untouched
      issue(0, 64'hA000, 5'd2, 0);
      wait_drain();
      cpl(7, 1'b0, 3);
      check_eq("unexp_out", 64'(outstanding), 64'd1);
      cpl(20, 1'b1, 3);
      check_eq("unexp_range_out", 64'(outstanding), 64'd1);

      // asynchronous reset mid-stream
      @(posedge clk); #1;
      rq_ready = 1'b0;
      issue(1, 64'hB000, 5'd5, 1);
      @(posedge clk); #1;
      req0_valid = 1'b1; req0_addr = 64'hB800; req0_len = 5'd3;
      #3;
      rstn = 1'b0;
      #1;
      exp_rq.delete();
      check_eq("arst_valid", 64'(rq_valid), 64'd0);
      check_eq("arst_addr", rq_addr, 64'd0);
      check_eq("arst_tag", 64'({rq_tag, 3'(rq_len)}), 64'd0);
      check_eq("arst_out", 64'(outstanding), 64'd0);
      check_eq("arst_ready", 64'(req0_ready), 64'd0);
      @(posedge clk); #1;
      req0_valid = 1'b0; rstn = 1'b1; rq_ready = 1'b1;
      issue(0, 64'hC000, 5'd6, 0);
      wait_drain();
      cpl(0, 1'b0, 0);
      wait_drain();
      check_eq("end_out", 64'(outstanding), 64'd0);
      check_eq("end_unexp", 64'(n_unexp_exp), 64'd0);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/rd_tag_scheduler.md
# rd_tag_scheduler

Read-request scheduler and tag manager for the PCIe requester path. Two internal requesters (req0, req1) share one requester-request (RQ) issue port. The block owns the pool of non-posted read tags and keeps per-tag context. It consumes the per-completion tag strobes produced by the requester-completion block: `select_tag`, `select_tag_valid` and `select_replay_cfg`. Each tag is then either retired or replayed with the same tag, and the owning requester is told the outcome.

## Interface
Parameters:
- TAG_W, 4, tag index width; NUM_TAGS = 2**TAG_W, legal 2..32 (TAG_W 1..5).
- ADDR_W, 64, request address width.
- MAX_RETRY, 3, replays allowed per tag before the request fails (0..7).

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-low, on ports `clk` and `rstn`.
- clk  in  1  clock.
- rstn  in  1  asynchronous active-low reset.
- srst  in  1  synchronous reset; same effect as rstn, applied at the clock edge.
- reqN_valid  in  1  requester N (N=0,1) has a read pending.
- reqN_ready  out  1  requester N accepted this cycle.
- reqN_addr  in  ADDR_W  DW-aligned read address.
- reqN_len  in  5  length in DW, 1..16.
- rq_valid  out  1  read request available on the RQ port.
- rq_ready  in  1  downstream accepts the RQ request.
- rq_addr  out  ADDR_W  address of the request on the RQ port.
- rq_len  out  5  length of the request on the RQ port.
- rq_tag  out  8  tag, zero-extended from TAG_W.
- select_tag  in  8  completion tag.
- select_tag_valid  in  1  one-cycle strobe per completion header.
- select_replay_cfg  in  1  qualifies select_tag_valid: completion status is an error.
- done_valid  out  1  one-cycle pulse: request retired.
- done_req  out  1  owning requester of the retired request.
- done_tag  out  8  retired tag.
- done_err  out  1  request failed after MAX_RETRY replays.
- unexp_cpl  out  1  one-cycle pulse: completion for a tag not in use, or select_tag ≥ NUM_TAGS.
- outstanding  out  TAG_W+1  number of tags in use.

## Operation
- Requests are single-completion only: len ≤ 16 DW.
- Per-tag state: busy bit, replay_pend bit, owner, addr, len, retry count (3 bits).
- Issue slot: one output register. The slot is loadable when it is empty, or when `rq_valid & rq_ready` this cycle.
- Source selection when the slot is loadable, in priority order:
  1. Lowest-index tag with replay_pend set. Reissue its stored addr/len with the same tag, then clear replay_pend.
  2. A new request, only if a free (non-busy) tag exists. Arbitration is round-robin between req0 and req1: the last granted requester gets lowest priority next time. The allocated tag is the lowest-index free tag. Stored context: owner, addr, len, retry=0; busy is set.
- reqN_ready is a single-cycle grant in the load cycle; the requester's payload is captured that cycle.
- Clean completion (`select_tag_valid & ~select_replay_cfg`, tag busy): clear busy, then pulse done with err=0 and the stored owner.
- Error completion (`select_tag_valid & select_replay_cfg`, tag busy):
  - If retry < MAX_RETRY: increment retry and set replay_pend.
  - Otherwise: clear busy and pulse done with err=1.
- Completion on a non-busy tag, on a tag whose replay is pending, or with select_tag ≥ NUM_TAGS: no state change; pulse unexp_cpl.
- outstanding equals the popcount of busy. A tag stays busy through its replays.

## Timing
- Reset values: all busy/replay_pend/retry bits 0; round-robin pointer at req0.
  - rq_valid, reqN_ready, done_valid, done_err, unexp_cpl, outstanding are 0.
  - rq_addr, rq_len, rq_tag, done_req, done_tag are 0.
- Reset in mid-operation drops the issue slot and all context. No done pulses are generated for discarded tags.
- Grant to rq_valid is 1 cycle: payload captured at edge N, rq_valid high from N+1.
- rq_valid stays asserted and the payload stays stable until rq_ready. Back-to-back issue is one request per cycle.
- A completion strobe at edge N produces done_valid/unexp_cpl at N+1 (registered pulses, no backpressure).
- A tag freed at edge N becomes allocatable from cycle N+1; allocation uses the registered busy vector.
- A replay_pend set at edge N is eligible for the issue slot from cycle N+1.
- Pool full (outstanding == NUM_TAGS): reqN_ready stays 0, but replays still issue.
- Completion and allocation in the same cycle must not collide. Allocation never selects the tag being completed, because that tag is still busy in the registered vector.

## Test plan
- Single request: req0 addr 0x1000, len 4 -> rq_valid next cycle with tag 0, len 4. Then clean completion on tag 0 -> done_valid, done_req=0, done_tag=0, err=0; outstanding returns to 0.
- Arbitration: req0 and req1 held continuously valid, rq_ready=1 -> grants alternate 0,1,0,1 with tags 0,1,2,3.
- Exhaustion (TAG_W=4): 16 requests issued with no completions -> outstanding=16, reqN_ready low. Complete tag 5 -> the next request gets tag 5 one cycle after the done pulse.
- Replay: error completion on tag 2 three times -> three reissues with tag 2 and the original addr/len. Fourth error -> done_err=1, tag 2 freed.
- Backpressure: rq_ready=0 for 10 cycles -> rq_valid held with stable payload and no further grants. Replay priority: a pending replay plus req0 valid -> the replay issues first.
- Unexpected completion: select_tag_valid on a free tag 7 -> unexp_cpl pulse, outstanding unchanged. Then assert rstn low mid-stream -> all outputs return to reset values.
